// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch target buffer and its resolve logic.
package branch_pkg;

  typedef enum logic [1:0] {
    BrBeq  = 2'd0,
    BrBne  = 2'd1,
    BrBltz = 2'd2,
    BrBgez = 2'd3
  } br_type_e;

  localparam logic [1:0] CTR_INIT  = 2'd1;
  localparam logic [1:0] CTR_ALLOC = 2'd2;

  // Width-independent part of an entry; tag and target widths are module
  // parameters, so the table keeps them in parallel arrays.
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
    return (ctr == 2'd3) ? ctr : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
    return (ctr == 2'd0) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Fetch-side prediction and ID-side resolve signals of the branch predictor.
interface branch_predict_resolve_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) ();

  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic              id_valid;
  logic              id_stall;
  logic              id_is_branch;
  logic [1:0]        id_br_type;
  logic              id_zero;
  logic              id_one;
  logic              id_comp_out;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_target;
  logic              id_pred_taken;
  logic [ADDR_W-1:0] id_pred_target;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  mispred_count;

  modport master (
    output if_pc, id_valid, id_stall, id_is_branch, id_br_type, id_zero, id_one,
           id_comp_out, id_pc, id_target, id_pred_taken, id_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, br_count, mispred_count
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_is_branch, id_br_type, id_zero, id_one,
           id_comp_out, id_pc, id_target, id_pred_taken, id_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, br_count, mispred_count
  );

endinterface

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: one asynchronous lookup port and one synchronous
// read-modify-write training port.
module btb_table
  import branch_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned TAG_W    = 26,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [1:0]          rd_ctr,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [ADDR_W-1:0]   rd_target,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                wr_taken,
  input  logic [ADDR_W-1:0]   wr_target
);

  localparam int Entries = 1 << IDX_BITS;

  btb_entry_t        ctl_q    [Entries];
  logic [TAG_W-1:0]  tag_q    [Entries];
  logic [ADDR_W-1:0] target_q [Entries];

  btb_entry_t wr_old;
  logic       wr_hit;

  always_comb begin
    rd_valid  = ctl_q[rd_idx].valid;
    rd_ctr    = ctl_q[rd_idx].ctr;
    rd_tag    = tag_q[rd_idx];
    rd_target = target_q[rd_idx];
    wr_old    = ctl_q[wr_idx];
    wr_hit    = wr_old.valid && (tag_q[wr_idx] == wr_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        ctl_q[i]    <= '{valid: 1'b0, ctr: CTR_INIT};
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctl_q[wr_idx].ctr <= wr_taken ? ctr_inc(wr_old.ctr) : ctr_dec(wr_old.ctr);
        if (wr_taken) target_q[wr_idx] <= wr_target;
      end else if (wr_taken) begin
        // Miss on a taken branch evicts whatever lived at this index.
        ctl_q[wr_idx]    <= '{valid: 1'b1, ctr: CTR_ALLOC};
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
      end
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// BTB-based next-PC prediction in IF, branch resolution and redirect in ID,
// one-cycle-delayed table training and saturating statistics.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 16
) (
  input logic                     clk,
  input logic                     rst,
  branch_predict_resolve_if.slave bus
);

  localparam int unsigned TAG_W = ADDR_W - IDX_BITS - 2;

  logic                rd_valid;
  logic [1:0]          rd_ctr;
  logic [TAG_W-1:0]    rd_tag;
  logic [ADDR_W-1:0]   rd_target;
  logic                hit;

  logic                actual_taken;
  logic                mispredict;
  logic                resolve;

  logic                upd_valid_q;
  logic [IDX_BITS-1:0] upd_idx_q;
  logic [TAG_W-1:0]    upd_tag_q;
  logic                upd_taken_q;
  logic [ADDR_W-1:0]   upd_target_q;

  logic [CNT_W-1:0]    br_count_q;
  logic [CNT_W-1:0]    mispred_count_q;

  btb_table #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W),
    .ADDR_W   (ADDR_W)
  ) u_btb_table (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.if_pc[IDX_BITS+1:2]),
    .rd_valid  (rd_valid),
    .rd_ctr    (rd_ctr),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .wr_en     (upd_valid_q),
    .wr_idx    (upd_idx_q),
    .wr_tag    (upd_tag_q),
    .wr_taken  (upd_taken_q),
    .wr_target (upd_target_q)
  );

  always_comb begin
    hit             = rd_valid && (rd_tag == bus.if_pc[ADDR_W-1:IDX_BITS+2]);
    bus.pred_taken  = hit && rd_ctr[1];
    bus.pred_target = bus.pred_taken ? rd_target : bus.if_pc + ADDR_W'(4);
  end

  always_comb begin
    unique case (br_type_e'(bus.id_br_type))
      BrBeq:   actual_taken = bus.id_zero;
      BrBne:   actual_taken = bus.id_one;
      default: actual_taken = bus.id_comp_out;
    endcase
    resolve    = bus.id_valid && bus.id_is_branch && !bus.id_stall;
    mispredict = (actual_taken != bus.id_pred_taken) ||
                 (actual_taken && (bus.id_target != bus.id_pred_target));
    bus.redirect    = resolve && mispredict;
    bus.redirect_pc = actual_taken ? bus.id_target : bus.id_pc + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_q     <= 1'b0;
      upd_idx_q       <= '0;
      upd_tag_q       <= '0;
      upd_taken_q     <= 1'b0;
      upd_target_q    <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      upd_valid_q <= resolve;
      if (resolve) begin
        upd_idx_q    <= bus.id_pc[IDX_BITS+1:2];
        upd_tag_q    <= bus.id_pc[ADDR_W-1:IDX_BITS+2];
        upd_taken_q  <= actual_taken;
        upd_target_q <= bus.id_target;
      end
      if (resolve && (br_count_q != {CNT_W{1'b1}})) begin
        br_count_q <= br_count_q + CNT_W'(1);
      end
      if (bus.redirect && (mispred_count_q != {CNT_W{1'b1}})) begin
        mispred_count_q <= mispred_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.br_count      = br_count_q;
  assign bus.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed scenarios plus random traffic
// compared against an array-based behavioural predictor model.
module tb_branch_predict_resolve;

  logic clk;
  logic rst;

  branch_predict_resolve_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  branch_predict_resolve #(
    .IDX_BITS (4),
    .ADDR_W   (32),
    .CNT_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          p_v;
  int          p_idx;
  logic [25:0] p_tag;
  bit          p_taken;
  logic [31:0] p_tgt;
  int          m_br;
  int          m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
    p_v   = 0;
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic model_apply();
    if (m_valid[p_idx] && m_tag[p_idx] == p_tag) begin
      if (p_taken) begin
        m_ctr[p_idx] = (m_ctr[p_idx] < 3) ? m_ctr[p_idx] + 1 : 3;
        m_tgt[p_idx] = p_tgt;
      end else begin
        m_ctr[p_idx] = (m_ctr[p_idx] > 0) ? m_ctr[p_idx] - 1 : 0;
      end
    end else if (p_taken) begin
      m_valid[p_idx] = 1;
      m_tag[p_idx]   = p_tag;
      m_tgt[p_idx]   = p_tgt;
      m_ctr[p_idx]   = 2;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input bit chk);
    int          idx;
    bit          exp_pt, act, res, mis;
    logic [31:0] exp_ptgt, exp_rpc;
    #1;
    idx      = int'(bus.if_pc[5:2]);
    exp_pt   = m_valid[idx] && (m_tag[idx] == bus.if_pc[31:6]) && (m_ctr[idx] >= 2);
    exp_ptgt = exp_pt ? m_tgt[idx] : bus.if_pc + 32'd4;
    case (bus.id_br_type)
      2'd0:    act = bus.id_zero;
      2'd1:    act = bus.id_one;
      default: act = bus.id_comp_out;
    endcase
    res     = bus.id_valid && bus.id_is_branch && !bus.id_stall;
    mis     = (act != bus.id_pred_taken) || (act && bus.id_target != bus.id_pred_target);
    exp_rpc = act ? bus.id_target : bus.id_pc + 32'd4;
    if (chk) begin
      check("pred_taken", 32'(bus.pred_taken), 32'(exp_pt));
      check("pred_target", bus.pred_target, exp_ptgt);
      check("redirect", 32'(bus.redirect), 32'(res && mis));
      if (res && mis) check("redirect_pc", bus.redirect_pc, exp_rpc);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (p_v) model_apply();
      p_v = res;
      if (res) begin
        p_idx   = int'(bus.id_pc[5:2]);
        p_tag   = bus.id_pc[31:6];
        p_taken = act;
        p_tgt   = bus.id_target;
        if (m_br < 65535) m_br++;
        if (mis && m_mis < 65535) m_mis++;
      end
    end
    @(negedge clk);
    if (chk) begin
      check("br_count", 32'(bus.br_count), 32'(m_br));
      check("mispred_count", 32'(bus.mispred_count), 32'(m_mis));
    end
  endtask

  task automatic no_branch();
    bus.id_valid     = 1'b0;
    bus.id_stall     = 1'b0;
    bus.id_is_branch = 1'b0;
  endtask

  task automatic set_br(input logic [1:0] ty, input bit z, input bit o, input bit c,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input bit pt, input logic [31:0] ptgt);
    bus.id_valid       = 1'b1;
    bus.id_stall       = 1'b0;
    bus.id_is_branch   = 1'b1;
    bus.id_br_type     = ty;
    bus.id_zero        = z;
    bus.id_one         = o;
    bus.id_comp_out    = c;
    bus.id_pc          = pc;
    bus.id_target      = tgt;
    bus.id_pred_taken  = pt;
    bus.id_pred_target = ptgt;
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h100 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    rst    = 1'b1;
    bus.if_pc = 32'h0;
    set_br(2'd0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    no_branch();
    model_reset();
    @(negedge clk);
    step(1);
    step(1);
    rst = 1'b0;

    // Reset state
    bus.if_pc = 32'h100;
    #1;
    check("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("rst_pred_target", bus.pred_target, 32'h104);
    check("rst_br_count", 32'(bus.br_count), 32'd0);
    check("rst_mis_count", 32'(bus.mispred_count), 32'd0);
    step(1);

    // BEQ taken, predicted not taken: redirect and allocate
    set_br(2'd0, 1, 0, 0, 32'h100, 32'h200, 0, 32'h104);
    #1;
    check("beq_redirect", 32'(bus.redirect), 32'd1);
    check("beq_redirect_pc", bus.redirect_pc, 32'h200);
    step(1);
    no_branch();
    step(1);
    #1;
    check("beq_trained_taken", 32'(bus.pred_taken), 32'd1);
    check("beq_trained_target", bus.pred_target, 32'h200);
    step(1);

    // BNE not taken, predicted taken: redirect to fall-through, ctr 2->1
    set_br(2'd1, 0, 0, 0, 32'h100, 32'h200, 1, 32'h200);
    #1;
    check("bne_redirect", 32'(bus.redirect), 32'd1);
    check("bne_redirect_pc", bus.redirect_pc, 32'h104);
    step(1);
    no_branch();
    step(1);
    #1;
    check("bne_trained_nt", 32'(bus.pred_taken), 32'd0);
    check("bne_trained_pc4", bus.pred_target, 32'h104);
    step(1);

    // BGEZ taken with wrong predicted target
    set_br(2'd3, 0, 0, 1, 32'h180, 32'h340, 1, 32'h300);
    #1;
    check("bgez_redirect", 32'(bus.redirect), 32'd1);
    check("bgez_redirect_pc", bus.redirect_pc, 32'h340);
    step(1);
    no_branch();
    check("bgez_mis_count", 32'(bus.mispred_count), 32'd3);

    // Stalled mispredicting branch resolves once the stall drops
    set_br(2'd0, 1, 0, 0, 32'h1c0, 32'h400, 0, 32'h1c4);
    bus.id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_no_redirect", 32'(bus.redirect), 32'd0);
      step(1);
      check("stall_br_count", 32'(bus.br_count), 32'd3);
    end
    bus.id_stall = 1'b0;
    #1;
    check("unstall_redirect", 32'(bus.redirect), 32'd1);
    step(1);
    no_branch();
    check("unstall_br_count", 32'(bus.br_count), 32'd4);

    // Aliasing: 0x140 shares the index of 0x100 and evicts it
    set_br(2'd0, 1, 0, 0, 32'h100, 32'h220, 0, 32'h104);
    step(1);
    set_br(2'd0, 1, 0, 0, 32'h140, 32'h240, 0, 32'h144);
    step(1);
    no_branch();
    bus.if_pc = 32'h100;
    step(1);
    step(1);
    #1;
    check("alias_miss", 32'(bus.pred_taken), 32'd0);
    check("alias_miss_pc4", bus.pred_target, 32'h104);
    bus.if_pc = 32'h140;
    #1;
    check("alias_hit_target", bus.pred_target, 32'h240);
    step(1);

    // Random traffic, with occasional mid-run reset
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      bus.if_pc = rand_pc();
      set_br(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
             rand_pc(), rand_pc() + 32'h1000, 1'($urandom), 32'h0);
      bus.id_pred_target = ($urandom_range(0, 1) == 0) ? bus.id_target : rand_pc();
      bus.id_valid       = ($urandom_range(0, 7) != 0);
      bus.id_is_branch   = ($urandom_range(0, 5) != 0);
      bus.id_stall       = ($urandom_range(0, 4) == 0);
      step(1);
    end
    rst = 1'b0;

    // Saturation of both counters
    rst = 1'b1;
    no_branch();
    step(1);
    rst = 1'b0;
    set_br(2'd0, 1, 0, 0, 32'h100, 32'h500, 0, 32'h104);
    for (int n = 0; n < 32'h10000 + 4; n++) step(0);
    no_branch();
    step(1);
    check("sat_br_count", 32'(bus.br_count), 32'hffff);
    check("sat_mis_count", 32'(bus.mispred_count), 32'hffff);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Direct-mapped branch target buffer with 2-bit direction counters, plus the branch resolution logic that consumes the ID-stage comparator flags (`zero`, `one`, `compOUT`).
- In IF, it predicts the next PC for the fetch address.
- In ID, it checks the actual outcome against the prediction carried down the pipe.
- On a mismatch, it redirects fetch and flushes IF/ID.
- It trains the table one clock later and keeps saturating statistics.

## Interface
- `IDX_BITS`, default 4: table index width; 2^IDX_BITS entries.
- `ADDR_W`, default 32: PC width.
- `CNT_W`, default 16: statistics counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_pc` in ADDR_W: current fetch PC.
- `pred_taken` out 1: IF prediction, taken.
- `pred_target` out ADDR_W: predicted next PC. Equals `if_pc`+4 when not taken.
- `id_valid` in 1: ID stage holds a valid instruction.
- `id_stall` in 1: ID stage is held this cycle.
- `id_is_branch` in 1: ID instruction is a conditional branch.
- `id_br_type` in 2: branch type. 0=BEQ, 1=BNE, 2=BLTZ, 3=BGEZ.
- `id_zero`, `id_one`, `id_comp_out` in 1 each: comparator flags for the ID instruction.
- `id_pc` in ADDR_W: PC of the branch.
- `id_target` in ADDR_W: computed branch target.
- `id_pred_taken` in 1: prediction recorded when the branch was fetched.
- `id_pred_target` in ADDR_W: predicted PC recorded when the branch was fetched.
- `redirect` out 1: fetch redirect; also used as the IF/ID flush.
- `redirect_pc` out ADDR_W: correct next PC.
- `br_count` out CNT_W: number of resolved branches.
- `mispred_count` out CNT_W: number of mispredictions.

## Operation
- Index is `pc[IDX_BITS+1:2]`. Tag is `pc[ADDR_W-1:IDX_BITS+2]`.
- Each entry holds `valid`, `tag`, `target` (ADDR_W bits) and `ctr` (2 bits).
- **Prediction (combinational):**
  - Hit means `valid` is set and the entry tag equals the `if_pc` tag.
  - `pred_taken` = hit & `ctr[1]`.
  - `pred_target` = entry `target` when `pred_taken`, otherwise `if_pc`+4 (wraps modulo 2^ADDR_W).
- **Resolve:** occurs when `id_valid` & `id_is_branch` & !`id_stall`.
  - Actual taken: BEQ=`id_zero`, BNE=`id_one`, BLTZ=`id_comp_out`, BGEZ=`id_comp_out`.
  - Mispredict when actual != `id_pred_taken`, or when both are taken and `id_target` != `id_pred_target`.
  - `redirect` = resolve & mispredict.
  - `redirect_pc` = `id_target` if actual taken, else `id_pc`+4. It is driven every cycle; its value is don't-care when `redirect`=0.
- **Update:** on resolve, {index, tag, taken, target} is latched into an update register. The table write happens on the next edge, so a one-entry write pipeline sits between resolve and the table.
  - Hit: `ctr` saturates toward 3 if taken, toward 0 if not taken. `target` is rewritten on taken.
  - Miss and taken: allocate the entry (overwrite) with `valid`=1, the new tag, the target, and `ctr`=2.
  - Miss and not taken: no write.
- **Statistics:** `br_count` increments on every resolve. `mispred_count` increments on every `redirect`. Both saturate at all-ones.
- **Stall:** while `id_stall`=1 there is no resolve, no `redirect`, no latch and no count. The branch resolves on the first unstalled cycle.

## Timing
- Prediction has zero latency: `pred_*` follow `if_pc` in the same cycle.
- `redirect` and `redirect_pc` are combinational from the ID inputs in the resolve cycle. The pipeline acts on them at the same edge.
- Table contents change two edges after the resolve cycle begins: the first edge latches the update register, the second writes the table.
- An IF lookup of an index with a pending or same-cycle write sees the old entry. There is no bypass.
- Back-to-back resolves on consecutive cycles each update in order, and both are applied.
- **Reset:**
  - All table entries: `valid`=0, `ctr`=1.
  - Update register: invalid.
  - `br_count` and `mispred_count`: 0.
  - Combinational outputs follow their inputs, so after reset `pred_taken`=0 and `pred_target`=`if_pc`+4.
- Reset asserted mid-operation discards the pending update. A branch resolving in the reset cycle still drives `redirect` combinationally, but it is not counted and not trained.

## Structure
- Shared package `branch_pkg` holds:
  - the `br_type_e` enum (BEQ/BNE/BLTZ/BGEZ);
  - the BTB entry struct;
  - the `CTR_INIT`=1 and `CTR_ALLOC`=2 constants;
  - the saturating-counter increment/decrement functions.
- One natural sub-module, `btb_table`: a register array with one asynchronous read port and one synchronous write port, plus synchronous reset.
- Resolve logic, update register and statistics stay in the top-level module.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104, both counters 0.
- BEQ at 0x100 with `id_zero`=1, `id_pred_taken`=0, target 0x200 → `redirect`=1, `redirect_pc`=0x200. Two edges later, `if_pc`=0x100 gives `pred_taken`=1, `pred_target`=0x200.
- Same branch resolves not-taken (BNE, `id_one`=0) with `id_pred_taken`=1 → `redirect`, `redirect_pc`=0x104, `ctr` goes 2→1. The next lookup predicts not taken.
- BGEZ with `id_comp_out`=1, predicted taken to 0x300, actual target 0x340 → `redirect`, `redirect_pc`=0x340, `mispred_count`+1.
- `id_stall`=1 for 3 cycles with a valid mispredicting branch → no `redirect` and no count until the stall drops, then exactly one `redirect` and `br_count`+1.
- Drive 0x10000 resolves with mispredicts at CNT_W=16 → both counters hold at 0xFFFF. Two taken branches aliasing the same index (0x100 and 0x140) → the second overwrites the tag, and a 0x100 lookup then misses.
